eth_dibit_feeder: RTL and testbench
===================================

Name: eth_dibit_feeder

Overview:
- Upstream neighbour of the Ethernet frame packer.
- Accepts payload bytes over a valid/ready interface and serializes them into RMII-order dibits for the packer's data field.
- Advances one dibit on every cycle the packer holds stall low.
- Detects underflow (packer wants data, none buffered), pulses cancelled to abort the frame, then discards the rest of that frame's bytes so the next frame starts aligned.

Parameters:
- FRAME_BYTES, 320: payload bytes per frame. The packer's stall-low window per frame is exactly FRAME_BYTES*4 cycles.
- CNT_W, 9: width of byte counters; must satisfy 2^CNT_W > FRAME_BYTES.

Ports:
- clk  input  1  system clock (50 MHz RMII domain)
- rst  input  1  synchronous, active-high reset
- byte_valid  input  1  upstream byte available
- byte_data  input  8  upstream payload byte
- byte_ready  output  1  feeder accepts byte this cycle (transfer = byte_valid & byte_ready)
- stall  input  1  from packer; low = consume one dibit this cycle
- axiov  output  1  dibit valid (current byte register occupied)
- axiod  output  2  current dibit to packer
- cancelled  output  1  one-cycle abort pulse to packer
- frame_done  output  1  one-cycle pulse when the last dibit of a frame is consumed

Behaviour:
- Storage: two byte slots, CUR (being serialized, with 2-bit dibit index DI) and NXT (prefetch). A byte moves NXT→CUR in the same cycle CUR's last dibit is consumed, so there is no bubble at byte boundaries.
- Outputs:
  - axiov = CUR valid.
  - axiod = {CUR[2*DI+1], CUR[2*DI]}; DI=0 first, i.e. LSb pair first.
  - axiod = 0 when axiov = 0.
  - axiov and axiod are combinational from registers.
- Consume event: state STREAM/IDLE & !stall & axiov. DI increments; on DI=3 the slot empties or refills from NXT.
- byte_ready = (NXT empty or NXT moving to CUR this cycle) & bytes_in < FRAME_BYTES & state != ABORT; in ABORT, byte_ready = (bytes_in < FRAME_BYTES).
- bytes_in counts bytes accepted for the current frame. It clears on entry to IDLE from STREAM or ABORT, and never exceeds FRAME_BYTES.
- Empty-slot fill: an accepted byte goes to CUR if CUR is empty (and not refilled from NXT), else to NXT.
- FSM:
  - IDLE: prefetch allowed. On !stall: if axiov, consume and go to STREAM; else underflow → ABORT.
  - STREAM: consume on !stall. The dibit counter counts up to FRAME_BYTES*4. When the last dibit is consumed: frame_done=1 next cycle, go to IDLE, clear bytes_in. !stall & !axiov → ABORT.
  - ABORT: on entry, register cancelled=1 for exactly one cycle. Flush CUR/NXT, clear the dibit counter, ignore stall. Accept and discard bytes until bytes_in == FRAME_BYTES, then go to IDLE and clear bytes_in.
- Latency:
  - Byte accepted at cycle t into empty CUR → axiov=1 at t+1.
  - Underflow detected at t → cancelled=1 at t+1.
- Simultaneous: consume of CUR's last dibit, NXT→CUR move, and a new byte into NXT can all occur in one cycle.
- Stall high: state, DI, and outputs hold.
- Reset (any state, mid-frame included): state=IDLE, CUR/NXT empty, DI=0, counters=0. Outputs: byte_ready=1, axiov=0, axiod=0, cancelled=0, frame_done=0.

Optional Feature:
- FEEDER_MSB_FIRST_EN defined: dibit order reversed, axiod = {CUR[7-2*DI], CUR[6-2*DI]}, for sources that pre-reverse bits.
- Not defined: LSb-pair-first order as above.

Test Plan:
- FRAME_BYTES=4, bytes 0x1B,0xE4,0xFF,0x00 preloaded, stall low 16 cycles → axiod sequence 3,2,1,0, 0,1,2,3, 3,3,3,3, 0,0,0,0. frame_done pulses once, cancelled stays 0.
- Upstream valid only every 4th cycle, stall low continuously → no axiov gap at byte boundaries (NXT refills in time); byte_ready drops once 4 bytes are accepted, until frame_done.
- stall low at IDLE with no bytes present → cancelled=1 the next cycle for one cycle, axiov=0, state ABORT; then 4 bytes accepted and discarded; the next frame's first byte appears on axiov.
- Mid-frame underflow after 2 of 4 bytes (upstream stops) → cancelled pulse; the remaining 2 bytes are discarded when they arrive; the following frame's byte 0x1B emits 3 first.
- stall toggling high/low every cycle over a full frame → same 16-dibit sequence, DI holds while stall is high.
- rst asserted mid-frame with both slots full → next cycle axiov=0, byte_ready=1, cancelled=0, bytes_in=0; with FEEDER_MSB_FIRST_EN, 0x1B emits 0,1,2,3.

Source files
------------

// File: rtl/eth_dibit_feeder.sv
// Byte-to-dibit serializer feeding the Ethernet frame packer; aborts and realigns on underflow.
// Define FEEDER_MSB_FIRST_EN to emit the MS dibit of each byte first.
module eth_dibit_feeder #(
   parameter int FRAME_BYTES = 320,
   parameter int CNT_W       = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   input  logic       stall,
   output logic       axiov,
   output logic [1:0] axiod,
   output logic       cancelled,
   output logic       frame_done
);

   // state  | meaning
   // IDLE   | between frames, prefetching; first unstalled cycle starts the frame or aborts
   // STREAM | frame in progress, one dibit per unstalled cycle
   // ABORT  | underflow seen; flush slots and swallow the rest of this frame's bytes
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ABORT} state_t;

   localparam int DIB_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] FRAME_N  = CNT_W'(FRAME_BYTES);
   localparam logic [CNT_W-1:0] BYTE_ONE = CNT_W'(1);
   localparam logic [DIB_W-1:0] DIB_LOAD = DIB_W'(FRAME_BYTES * 4 - 1);
   localparam logic [DIB_W-1:0] DIB_ONE  = DIB_W'(1);

   state_t r_state, w_state_nxt;

   logic [7:0]       r_cur, r_nxt;
   logic             r_cur_v, r_nxt_v;
   logic [1:0]       r_di;
   logic [CNT_W-1:0] r_bytes_in;
   logic [DIB_W-1:0] r_dib_left;
   logic             r_cancelled, r_frame_done;

   logic       w_room, w_consume, w_cur_last, w_move, w_cur_free;
   logic       w_accept, w_last_dibit, w_flush, w_clr_bytes;
   logic [2:0] w_bit_lo;

   assign w_room     = (r_bytes_in < FRAME_N);
   assign w_consume  = (r_state != S_ABORT) & ~stall & r_cur_v;
   assign w_cur_last = w_consume & (r_di == 2'd3);
   assign w_move     = w_cur_last & r_nxt_v;
   // CUR counts as free when its last dibit leaves this cycle with nothing behind it
   assign w_cur_free = ~r_cur_v | (w_cur_last & ~r_nxt_v);

   assign byte_ready = (r_state == S_ABORT) ? w_room : ((~r_nxt_v | w_move) & w_room);
   assign w_accept   = byte_valid & byte_ready;

   assign w_last_dibit = (r_state == S_STREAM) & w_consume & (r_dib_left == DIB_ONE);
   assign w_flush      = (r_state == S_ABORT) | (w_state_nxt == S_ABORT);
   assign w_clr_bytes  = (r_state != S_IDLE) & (w_state_nxt == S_IDLE);

`ifdef FEEDER_MSB_FIRST_EN
   assign w_bit_lo = 3'd6 - {r_di, 1'b0};
`else
   assign w_bit_lo = {r_di, 1'b0};
`endif

   assign axiov      = r_cur_v;
   assign axiod      = r_cur_v ? r_cur[w_bit_lo +: 2] : 2'd0;
   assign cancelled  = r_cancelled;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!stall) begin
               w_state_nxt = r_cur_v ? S_STREAM : S_ABORT;
            end
         end
         S_STREAM: begin
            if (w_last_dibit) begin
               w_state_nxt = S_IDLE;
            end else if (!stall && !r_cur_v) begin
               w_state_nxt = S_ABORT;
            end
         end
         S_ABORT: begin
            if (r_bytes_in == FRAME_N) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur        <= 8'd0;
         r_nxt        <= 8'd0;
         r_cur_v      <= 1'b0;
         r_nxt_v      <= 1'b0;
         r_di         <= 2'd0;
         r_bytes_in   <= '0;
         r_dib_left   <= '0;
         r_cancelled  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_cancelled  <= (w_state_nxt == S_ABORT) && (r_state != S_ABORT);
         r_frame_done <= w_last_dibit;

         if (w_clr_bytes) begin
            r_bytes_in <= '0;
         end else if (w_accept) begin
            r_bytes_in <= r_bytes_in + BYTE_ONE;
         end

         if (w_flush) begin
            r_cur_v    <= 1'b0;
            r_nxt_v    <= 1'b0;
            r_di       <= 2'd0;
            r_dib_left <= '0;
         end else begin
            if (w_consume) begin
               r_di <= r_di + 2'd1;
            end

            if (w_move) begin
               r_cur   <= r_nxt;
               r_cur_v <= 1'b1;
            end else if (w_accept && w_cur_free) begin
               r_cur   <= byte_data;
               r_cur_v <= 1'b1;
            end else if (w_cur_last) begin
               r_cur_v <= 1'b0;
            end

            if (w_accept && !w_cur_free) begin
               r_nxt   <= byte_data;
               r_nxt_v <= 1'b1;
            end else if (w_move) begin
               r_nxt_v <= 1'b0;
            end

            // down-counter of dibits left in the frame; terminal count is 1
            if (w_consume && r_state == S_IDLE) begin
               r_dib_left <= DIB_LOAD;
            end else if (w_consume && r_state == S_STREAM) begin
               r_dib_left <= r_dib_left - DIB_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_dibit_feeder.sv
// Self-checking bench for eth_dibit_feeder with a 4-byte frame; dibit scoreboard plus corner sequences.
// Honours FEEDER_MSB_FIRST_EN for the expected dibit order.
module tb_eth_dibit_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       stall;
   logic       axiov;
   logic [1:0] axiod;
   logic       cancelled;
   logic       frame_done;

   eth_dibit_feeder #(.FRAME_BYTES(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .stall      (stall),
      .axiov      (axiov),
      .axiod      (axiod),
      .cancelled  (cancelled),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // expected dibit sequences, first dibit in [7:6]
   typedef struct {
      logic [7:0] b;
      logic [7:0] lsb;
      logic [7:0] msb;
   } vec_t;

   vec_t       tbl [8];
   logic [1:0] q [$];

   int n_vec = 0;
   int n_err = 0;
   int n_done, n_canc;
   int n_i, sent_i;

   logic       s_v, s_rdy, s_canc, s_fd, s_con, s_acc;
   logic [1:0] s_d, first_d;
   logic       prev_v = 1'b0, prev_st = 1'b1;
   logic [1:0] prev_d = 2'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_seq(input int i);
`ifdef FEEDER_MSB_FIRST_EN
      return tbl[i].msb;
`else
      return tbl[i].lsb;
`endif
   endfunction

   // one clock: drive at negedge, sample 2ns later, then wait for next negedge
   task automatic cyc(input bit v, input int idx, input bit st, input bit keep);
      logic [7:0] sq;
      byte_valid = v;
      byte_data  = v ? tbl[idx].b : 8'h00;
      stall      = st;
      #2;
      s_v = axiov; s_d = axiod; s_rdy = byte_ready; s_canc = cancelled; s_fd = frame_done;
      s_con = s_v && !st;
      s_acc = v && s_rdy;
      if (s_fd) n_done++;
      if (s_canc) n_canc++;
      if (!s_v) chk("axiod_when_invalid", s_d, 0);
      if (prev_v && prev_st && s_v) chk("hold_on_stall", s_d, prev_d);
      if (s_con) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_dibit: got %0d, expected no valid dibit", s_d);
         end else begin
            chk("dibit", s_d, q.pop_front());
         end
      end
      if (s_acc && keep) begin
         sq = exp_seq(idx);
         for (int k = 0; k < 4; k++) q.push_back(sq[7-2*k -: 2]);
      end
      prev_v = s_v; prev_st = st; prev_d = s_d;
      @(negedge clk);
   endtask

   // one whole frame from IDLE: bytes base..base+3, one offered every 'period' cycles
   task automatic run_frame(input int base, input int period, input bit toggle);
      int n, sent, cons, rdy_bad, need;
      bit pend, st, tg, done_seen, got_first;
      logic [7:0] fs;
      n = 0; sent = 0; cons = 0; rdy_bad = 0;
      pend = 0; tg = 0; done_seen = 0; got_first = 0;
      need = (period == 1) ? 2 : 1;
      n_done = 0; n_canc = 0;
      first_d = 2'd0;
      while (!done_seen && n < 80) begin
         if (!pend && sent < 4 && (n % period == 0)) pend = 1;
         if (cons >= 16 || sent < need) st = 1;
         else begin
            st = toggle ? tg : 1'b0;
            tg = ~tg;
         end
         cyc(pend, (sent < 4) ? base + sent : base, st, 1'b1);
         if (s_con) begin
            if (!got_first) begin
               first_d = s_d;
               got_first = 1;
            end
            cons++;
         end
         if (sent == 4 && !s_fd && s_rdy) rdy_bad++;
         if (s_acc) begin
            sent++;
            pend = 0;
         end
         if (s_fd) done_seen = 1;
         n++;
      end
      fs = exp_seq(base);
      chk("frame_done_seen", done_seen, 1);
      chk("dibits_consumed", cons, 16);
      chk("cancel_in_frame", n_canc, 0);
      chk("ready_after_full", rdy_bad, 0);
      chk("scoreboard_left", q.size(), 0);
      chk("first_dibit", first_d, fs[7:6]);
      cyc(1'b0, 0, 1'b1, 1'b1);
      chk("frame_done_width", s_fd, 0);
   endtask

   initial begin
      tbl[0] = '{8'h1B, 8'hE4, 8'h1B};
      tbl[1] = '{8'hE4, 8'h1B, 8'hE4};
      tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
      tbl[3] = '{8'h00, 8'h00, 8'h00};
      tbl[4] = '{8'h5A, 8'hA5, 8'h5A};
      tbl[5] = '{8'hC3, 8'hC3, 8'hC3};
      tbl[6] = '{8'h27, 8'hD8, 8'h27};
      tbl[7] = '{8'h8D, 8'h72, 8'h8D};

      rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; stall = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      chk("reset_ready", byte_ready, 1);
      chk("reset_axiov", axiov, 0);
      chk("reset_axiod", axiod, 0);
      chk("reset_cancelled", cancelled, 0);
      chk("reset_frame_done", frame_done, 0);
      @(negedge clk);

      run_frame(0, 1, 1'b0);   // back-to-back bytes, continuous consume
      run_frame(4, 4, 1'b0);   // sparse upstream, no bubble at byte edges
      run_frame(0, 1, 1'b1);   // stall toggling every cycle

      // underflow straight out of IDLE
      n_canc = 0;
      cyc(1'b0, 0, 1'b0, 1'b0);
      chk("underflow_axiov", s_v, 0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("cancel_pulse", s_canc, 1);
      chk("abort_axiov", s_v, 0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("cancel_width", s_canc, 0);
      n_i = 0; sent_i = 0;
      while (sent_i < 4 && n_i < 20) begin
         cyc(1'b1, sent_i, 1'b0, 1'b0);
         if (s_acc) sent_i++;
         n_i++;
      end
      chk("discard_count", sent_i, 4);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("abort_full_ready", s_rdy, 0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("idle_ready", s_rdy, 1);
      chk("cancel_total", n_canc, 1);
      run_frame(4, 1, 1'b0);

      // mid-frame underflow after two bytes
      n_canc = 0;
      cyc(1'b1, 4, 1'b1, 1'b1);
      chk("mid_acc0", s_acc, 1);
      cyc(1'b1, 5, 1'b1, 1'b1);
      chk("mid_acc1", s_acc, 1);
      repeat (8) cyc(1'b0, 0, 1'b0, 1'b1);
      chk("mid_drained", q.size(), 0);
      cyc(1'b0, 0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("mid_cancel_pulse", s_canc, 1);
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("mid_cancel_width", s_canc, 0);
      n_i = 0; sent_i = 0;
      while (sent_i < 2 && n_i < 20) begin
         cyc(1'b1, 6 + sent_i, 1'b1, 1'b0);
         if (s_acc) sent_i++;
         n_i++;
      end
      chk("mid_discard_count", sent_i, 2);
      repeat (2) cyc(1'b0, 0, 1'b1, 1'b0);
      chk("mid_cancel_total", n_canc, 1);
      run_frame(0, 1, 1'b0);

      // reset mid-frame with both slots full
      cyc(1'b1, 4, 1'b1, 1'b1);
      cyc(1'b1, 5, 1'b1, 1'b1);
      repeat (3) cyc(1'b0, 0, 1'b0, 1'b1);
      rst = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA; stall = 1'b0;
      @(negedge clk);
      rst = 1'b0; byte_valid = 1'b0; stall = 1'b1;
      #2;
      chk("rst_mid_axiov", axiov, 0);
      chk("rst_mid_ready", byte_ready, 1);
      chk("rst_mid_cancelled", cancelled, 0);
      chk("rst_mid_axiod", axiod, 0);
      q.delete();
      prev_v = 1'b0;
      @(negedge clk);
      run_frame(0, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
